// File: rtl/rca_share_ctrl.sv
// Shares one external 32-bit ripple-carry adder between two requesters and
// sequences multi-word additions one word per cycle, least-significant word first.
module rca_share_ctrl #(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [32*WORDS-1:0]   req0_a,
    input  logic [32*WORDS-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [32*WORDS-1:0]   req1_a,
    input  logic [32*WORDS-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [32*WORDS-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_id,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_cin,
    input  logic [31:0]           add_sum,
    input  logic                  add_cout
);

    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] LAST_WORD = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic                    last;
    logic [KW-1:0]           k;
    logic                    carry_reg;
    logic                    cin_reg;
    logic                    id_reg;
    logic [WORDS-1:0][31:0]  a_reg;
    logic [WORDS-1:0][31:0]  b_reg;
    logic [WORDS-1:0][31:0]  sum_reg;

    logic grant0;
    logic grant1;

    // Round-robin: the requester that did not win last time takes a tie.
    assign grant0 = req0_valid && (!req1_valid || last);
    assign grant1 = req1_valid && !grant0;

    assign rsp_sum  = sum_reg;
    assign rsp_cout = carry_reg;
    assign rsp_id   = id_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                add_a   = a_reg[k];
                add_b   = b_reg[k];
                add_cin = (k == '0) ? cin_reg : carry_reg;
                if (k == LAST_WORD) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one adder word per RUN cycle with the
    // carry chained through carry_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            k         <= '0;
            carry_reg <= 1'b0;
            cin_reg   <= 1'b0;
            id_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_reg   <= grant1 ? req1_a : req0_a;
                        b_reg   <= grant1 ? req1_b : req0_b;
                        cin_reg <= grant1 ? req1_cin : req0_cin;
                        id_reg  <= grant1;
                        last    <= grant1;
                        k       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[k] <= add_sum;
                    carry_reg  <= add_cout;
                    if (k != LAST_WORD) begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rca_share_ctrl.md
# rca_share_ctrl

Sequencer and arbiter that shares one external 32-bit ripple-carry adder (RCA32bit) between two requesters and performs multi-word additions of 32·WORDS bits. Each accepted operation runs one 32-bit word per cycle, least-significant word first, with the carry held in a register between words. It sits between two client blocks and the single adder instance, so wide adds need no wide adder.

## Interface

- WORDS, 2, number of 32-bit words per operand (≥1); operand width W = 32·WORDS
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle (valid&&ready)
- req0_a, req0_b  in  W  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  W  result sum
- rsp_cout  out  1  carry-out of most-significant word
- rsp_id  out  1  requester that issued the result
- add_a, add_b  out  32  to shared adder
- add_cin  out  1  to shared adder
- add_sum  in  32  from shared adder (combinational, same cycle)
- add_cout  in  1  from shared adder

## Operation

- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: round-robin arbitration. Pointer `last` (reset value 1, so requester 0 wins first tie).
  - grant0 = req0_valid && (!req1_valid || last==1); grant1 = req1_valid && !grant0.
  - reqN_ready = (state==IDLE) && grantN. Ready depends combinationally on valid; it is never asserted outside IDLE.
  - On accept: latch a, b, cin, id. Set `last` = id and word index k = 0. Go to RUN.
- RUN: add_a = a_reg[32k+31:32k], add_b = b_reg[32k+31:32k], add_cin = (k==0) ? cin_reg : carry_reg.
  - Each cycle: sum_reg word k ← add_sum; carry_reg ← add_cout; k ← k+1.
  - When k == WORDS−1, go to DONE.
- DONE: rsp_valid=1. rsp_sum, rsp_cout (= final carry_reg) and rsp_id stay stable until rsp_valid && rsp_ready; then go to IDLE.
- Outside RUN, add_a, add_b and add_cin are driven 0.
- Arithmetic: result = a + b + cin modulo 2^W; rsp_cout = bit W of the full sum.
- No accept is possible while RUN or DONE. Requests keep valid asserted and wait; operands must stay stable until accepted.

## Timing

- Reset values: reqN_ready 0 (state IDLE and no valid), rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, add_* 0, last 1, k 0, carry_reg 0.
- Accept in cycle T. RUN occupies T+1 … T+WORDS. rsp_valid is first high in T+WORDS+1.
- With rsp_ready held high, the response handshake completes in T+WORDS+1 and the next accept occurs in T+WORDS+2. Peak throughput is one operation per WORDS+2 cycles.
- Reset mid-operation (RUN or DONE) aborts the operation. No response is produced, outputs return to reset values next cycle, and `last` returns to 1.
- rst has priority over every other event in the same cycle.
- WORDS=1: a single RUN cycle. add_cin is always cin_reg.

## Test plan

- Carry across words (WORDS=2): req0 a=0x00000000_FFFFFFFF, b=0x1, cin=0 → rsp_sum=0x00000001_00000000, rsp_cout=0, rsp_id=0, rsp_valid 3 cycles after accept.
- Full overflow: req1 a=0xFFFFFFFF_FFFFFFFF, b=0, cin=1 → rsp_sum=0, rsp_cout=1, rsp_id=1. add_cin=1 in first RUN cycle only, then carries 1.
- Tie after reset: req0 and req1 both valid in the same cycle → req0 accepted first, req1 accepted in the IDLE cycle after the req0 response. Both held valid continuously → grants alternate 0,1,0,1.
- Backpressure: rsp_ready low for 5 cycles in DONE → rsp_valid, rsp_sum and rsp_id stable, both readies low. Raising rsp_ready completes the response; the next accept happens one cycle later.
- Reset in RUN: assert rst in the first RUN cycle → no rsp_valid ever. Next tie is granted to req0. A subsequent 0+0, cin=1 operation returns rsp_sum=1, rsp_cout=0.
